// File: rtl/pipe_stage_pkg.sv
// Shared types and defaults for the elastic pipeline-stage register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_stage_pkg;

    // Occupancy state of the 2-entry stage. The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    // Default width of the optional statistics counters.
    localparam int PIPE_CNT_W_DEF = 16;

endpackage : pipe_stage_pkg

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear, used for stage statistics.
// Latency: count updates one cycle after inc/clear are sampled.
// Backpressure: none; inc is ignored once the count reaches all-ones.
//
// Ports:
//   CLK, nRST : clock (rising edge) and asynchronous active-low reset
//   i_inc     : add one this cycle (held at all-ones once saturated)
//   i_clear   : synchronous return to zero, wins over i_inc
//   o_cnt     : current count
module pipe_sat_cnt #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         i_inc,
    input  logic         i_clear,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule : pipe_sat_cnt

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: 2-entry skid buffer with valid/ready on both sides and flush.
// Latency: one cycle from in_valid/in_ready to out_valid; one beat per cycle while out_ready is high.
// Backpressure: in_ready is a flop decode (low only when both entries are full), so it does not depend on out_ready.
//
// Ports:
//   CLK, nRST            : clock (rising edge) and asynchronous active-low reset
//   flush                : synchronous squash of all held beats (same-cycle input beat discarded)
//   in_valid/in_ready    : upstream handshake, in_data is the payload
//   out_valid/out_ready  : downstream handshake, out_data is the head entry
//   occ                  : occupancy 0..2
//   stall_cnt, flush_cnt : statistics, present only when PIPE_STAGE_STATS_EN is defined
//
// Optional feature macro: PIPE_STAGE_STATS_EN.
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int                CNT_W     = PIPE_CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    stage_state_t      r_state;
    stage_state_t      w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    // State and storage registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= EMPTY;
            r_main  <= FLUSH_VAL;
            r_skid  <= FLUSH_VAL;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    // Next-state and storage update.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;

        if (flush) begin
            // Any out_xfer this cycle has already been sampled downstream; the rest is wrong-path.
            w_state_nxt = EMPTY;
            w_main_nxt  = FLUSH_VAL;
            w_skid_nxt  = FLUSH_VAL;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = in_data;
                    end
                end
                ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_main_nxt = in_data;
                    end else if (w_in_xfer) begin
                        // Head is stalled: park the new beat behind it.
                        w_state_nxt = TWO;
                        w_skid_nxt  = in_data;
                    end else if (w_out_xfer) begin
                        w_state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain can happen.
                    if (w_out_xfer) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    // Unused encoding: recover to a clean empty stage.
                    w_state_nxt = EMPTY;
                    w_main_nxt  = FLUSH_VAL;
                    w_skid_nxt  = FLUSH_VAL;
                end
            endcase
        end
    end

    // Outputs are decodes of flops only.
    assign out_valid = (r_state != EMPTY);
    assign in_ready  = (r_state != TWO);
    assign out_data  = r_main;

    always_comb begin
        occ = 2'd0;
        case (r_state)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
    end

`ifdef PIPE_STAGE_STATS_EN
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_stall_inc = out_valid & ~out_ready;
    // Only count flushes that actually discard held beats.
    assign w_flush_inc = flush & (r_state != EMPTY);

    pipe_sat_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_inc   (w_stall_inc),
        .i_clear (1'b0),
        .o_cnt   (stall_cnt)
    );

    pipe_sat_cnt #(
        .W (CNT_W)
    ) u_flush_cnt (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_inc   (w_flush_inc),
        .i_clear (1'b0),
        .o_cnt   (flush_cnt)
    );
`endif

endmodule : pipe_stage_reg

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised, elastic pipeline-stage register. It is the successor to the fixed IF/ID latch and serves any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the global enable with a valid/ready handshake per side.
- A 2-entry skid buffer lets in_ready be driven from a flop, not from out_ready.
- Synchronous flush squashes all held beats.

Parameters:
DATA_W, 64, payload width in bits (for example instr+npc = 32+32).
FLUSH_VAL, '0 (DATA_W bits), value loaded into both data registers on reset and flush; decodes as a NOP/bubble.
CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
CLK  input  1  clock, rising edge.
nRST  input  1  asynchronous active-low reset.
flush  input  1  synchronous squash of all held beats.
in_valid  input  1  upstream beat valid.
in_ready  output  1  stage can accept a beat.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  stage holds a beat for downstream.
out_ready  input  1  downstream accepts the beat.
out_data  output  DATA_W  payload presented downstream.
occ  output  2  current occupancy: 0, 1 or 2.

Behaviour:
- Transfer rules: in_xfer = in_valid & in_ready. out_xfer = out_valid & out_ready.
- Storage: main_q is the head entry, skid_q is the second entry.
- State is EMPTY, ONE or TWO (2-bit encoding).
- Outputs are pure decodes of the flops, with no combinational input-to-output path:
  - out_valid = (state != EMPTY)
  - in_ready = (state != TWO)
  - out_data = main_q
  - occ = 0, 1 or 2 for EMPTY, ONE, TWO.
- Reset (nRST low, asynchronous): state = EMPTY, main_q = skid_q = FLUSH_VAL. Therefore out_valid = 0, in_ready = 1, occ = 0, out_data = FLUSH_VAL.
- Latency: a beat accepted into EMPTY appears on out_data/out_valid the next cycle. Throughput is one beat per cycle while out_ready stays high.
- Transitions when flush = 0:
  - EMPTY: in_xfer -> ONE, main_q <= in_data.
  - ONE, in_xfer & out_xfer -> ONE, main_q <= in_data.
  - ONE, in_xfer only -> TWO, skid_q <= in_data.
  - ONE, out_xfer only -> EMPTY.
  - ONE, neither -> hold.
  - TWO: in_ready = 0, so in_xfer is impossible. out_xfer -> ONE, main_q <= skid_q. Otherwise hold.
- Flush (highest priority over everything except reset):
  - Next state = EMPTY, main_q = skid_q = FLUSH_VAL.
  - An in_xfer in the same cycle is discarded (wrong-path beat).
  - An out_xfer in the same cycle completes normally: downstream keeps the beat it sampled. The remaining beat in TWO is squashed.
- Ordering: beats leave in arrival order. No beat is duplicated or dropped, except by flush.
- Stall: holding out_ready = 0 fills the stage to TWO in at most 2 accepted beats. main_q and skid_q then stay stable.
- nRST asserted mid-transfer: immediate return to the reset state. An in-flight beat is lost; no partial update.

Optional Feature:
Macro PIPE_STAGE_STATS_EN.
- Defined: adds two outputs, stall_cnt (CNT_W) and flush_cnt (CNT_W), both reset to 0.
  - stall_cnt increments on every cycle with out_valid & ~out_ready.
  - flush_cnt increments on every cycle with flush = 1 and state != EMPTY (a squash that discards real beats).
  - Both counters saturate at all-ones and never wrap.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package pipe_stage_pkg holds:
  - typedef enum logic [1:0] {EMPTY, ONE, TWO} stage_state_t
  - localparam default CNT_W.
- One sub-module, pipe_sat_cnt (parameter W; inputs inc and clear; saturating output). It is instantiated twice, only under PIPE_STAGE_STATS_EN.

Test Plan:
1. Reset, then release with no activity -> out_valid = 0, in_ready = 1, occ = 0, out_data = 0.
2. Streaming: out_ready = 1 held, beats 0xA1..0xA4 on consecutive cycles -> each appears on out_data one cycle after acceptance, in order, occ stays 1, in_ready stays 1.
3. Backpressure: out_ready = 0, send 0xB1, 0xB2, 0xB3 -> 0xB1 and 0xB2 accepted, in_ready = 0 from the cycle after 0xB2, occ = 2. Release out_ready -> 0xB1, then 0xB2, then 0xB3 delivered.
4. Flush while in TWO, with out_ready = 1 and in_valid = 1 carrying 0xC9 in the same cycle -> current head completes, 0xC9 dropped. Next cycle: occ = 0, out_valid = 0, out_data = FLUSH_VAL.
5. nRST pulsed low mid-cycle while occ = 2 -> outputs return to reset values without waiting for CLK.
6. With PIPE_STAGE_STATS_EN and CNT_W = 2: stall for 5 cycles -> stall_cnt = 3 (saturated). Flush with occ = 1 -> flush_cnt = 1. Flush with occ = 0 -> flush_cnt unchanged.
